multi_channel_nco_divider: RTL and testbench

- Parametrised successor to the single-output frequency divider: NCH independent square-wave outputs from one system clock.
- Each channel is programmed with three BCD digits plus a unit code, using the same encoding as the keypad FSM.
- A shared sequential converter turns the digits into a millihertz increment, with a valid/ready handshake.
- Each channel runs a phase accumulator that keeps its remainder, so frequency resolution is fractional and updates are phase-continuous. Feeds the waveform generators.

---
 rtl/multi_channel_nco_divider.sv | 113 +++++++++++
 tb/tb_multi_channel_nco_divider.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/multi_channel_nco_divider.sv
`timescale 1ns/1ps
// multi_channel_nco_divider: NCH phase-accumulator square-wave outputs programmed by BCD digits + unit code.
// Optional PHASE_RESET_EN: a commit clears that channel's accumulator and output for an aligned phase start.
module multi_channel_nco_divider #(
  parameter int NCH = 2,
  parameter int unsigned CLK_HZ = 100000000,
  parameter int ACC_W = 40,
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1
) (
  input  logic             clk_100MHz,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CW-1:0]    cfg_ch,
  input  logic [3:0][3:0]  cfg_digit,
  output logic             cfg_done,
  output logic             cfg_err,
  input  logic [NCH-1:0]   run_en,
  output logic [NCH-1:0]   clk_out
);
  localparam logic [ACC_W-1:0] T = ACC_W'(64'(CLK_HZ) * 64'd500);
  if (NCH < 1 || NCH > 8 || !((64'd1 << ACC_W) > 64'd999_000_000_000 &&
      (64'd1 << ACC_W) > 64'(CLK_HZ) * 64'd1000)) begin : g_bad_param
    $error("multi_channel_nco_divider: NCH out of range or ACC_W too narrow for CLK_HZ");
  end
  typedef enum logic [1:0] {IDLE, CHECK, SCALE, COMMIT} state_t;
  state_t state;
  logic [CW-1:0] ch_q;
  logic [3:0][3:0] dig;
  logic [ACC_W-1:0] v, d0, d1, d2, v_init;
  logic [3:0] cnt, k;
  logic bad, dig_bad, commit_ok;
  always_comb begin
    d0 = ACC_W'(dig[0]);
    d1 = ACC_W'(dig[1]);
    d2 = ACC_W'(dig[2]);
    v_init = (d0 << 6) + (d0 << 5) + (d0 << 2) + (d1 << 3) + (d1 << 1) + d2;
    k = dig[3] == 4'hb ? 4'd3 : dig[3] == 4'hc ? 4'd6 : dig[3] == 4'hd ? 4'd9 : 4'd0;
    dig_bad = dig[0] > 4'd9 || dig[1] > 4'd9 || dig[2] > 4'd9 ||
              dig[3] < 4'ha || dig[3] > 4'hd || 32'(ch_q) >= NCH;
    commit_ok = state == COMMIT && !bad && v <= T;
  end
  // Digit errors are reported from COMMIT too, so every request answers exactly once.
  always_ff @(posedge clk_100MHz or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cfg_ready <= 1'b1;
      cfg_done <= 1'b0;
      cfg_err <= 1'b0;
      ch_q <= '0;
      dig <= '0;
      v <= '0;
      cnt <= '0;
      bad <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        IDLE: if (cfg_valid && cfg_ready) begin
          ch_q <= cfg_ch;
          dig <= cfg_digit;
          cfg_ready <= 1'b0;
          state <= CHECK;
        end
        CHECK: begin
          bad <= dig_bad;
          v <= v_init;
          cnt <= k;
          state <= (dig_bad || k == 4'd0) ? COMMIT : SCALE;
        end
        SCALE: begin
          v <= (v << 3) + (v << 1);
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= COMMIT;
        end
        COMMIT: begin
          cfg_done <= commit_ok;
          cfg_err <= !commit_ok;
          cfg_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [ACC_W-1:0] inc, acc, s;
    logic q, we;
    assign s = acc + inc;
    assign we = commit_ok && ch_q == CW'(i);
    assign clk_out[i] = q;
    always_ff @(posedge clk_100MHz or negedge rst) begin
      if (!rst) begin
        inc <= '0;
        acc <= '0;
        q <= 1'b0;
      end else begin
        if (we) inc <= v;
`ifdef PHASE_RESET_EN
        if (we || !run_en[i]) begin
`else
        if (!run_en[i]) begin
`endif
          acc <= '0;
          q <= 1'b0;
        end else if (s >= T) begin
          acc <= s - T;
          q <= ~q;
        end else acc <= s;
      end
    end
  end
endmodule

// File: tb/tb_multi_channel_nco_divider.sv
`timescale 1ns/1ps
// tb_multi_channel_nco_divider: directed checks of config handshake, latency, errors and output timing.
module tb_multi_channel_nco_divider;
  logic clk_100MHz = 1'b0;
  logic rst, cfg_valid, cfg_ready, cfg_done, cfg_err;
  logic [0:0] cfg_ch;
  logic [3:0][3:0] cfg_digit;
  logic [1:0] run_en, clk_out;
  int n_cmp = 0, n_bad = 0;
  multi_channel_nco_divider #(.NCH(2), .CLK_HZ(100000000), .ACC_W(40)) dut (
    .clk_100MHz(clk_100MHz), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_digit(cfg_digit), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .run_en(run_en), .clk_out(clk_out)
  );
  always #5 clk_100MHz = ~clk_100MHz;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic do_cfg(input logic [0:0] ch, input logic [3:0] a, b, c, u,
                        output int lat, output logic dn, output logic er, output logic rdy1);
    cfg_ch = ch;
    cfg_digit = {u, c, b, a};
    cfg_valid = 1'b1;
    @(posedge clk_100MHz);
    #1 cfg_valid = 1'b0;
    lat = -1;
    dn = 1'b0;
    er = 1'b0;
    rdy1 = 1'bx;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(posedge clk_100MHz);
      @(negedge clk_100MHz);
      if (n == 1) rdy1 = cfg_ready;
      if (cfg_done || cfg_err) begin
        lat = n;
        dn = cfg_done;
        er = cfg_err;
      end
    end
    chk("cfg_wait_expired", lat >= 0, 1'b1);
  endtask
  task automatic wait_toggle(input int idx, output int n);
    logic p;
    p = clk_out[idx];
    n = -1;
    for (int c = 1; c <= 300 && n < 0; c++) begin
      @(posedge clk_100MHz);
      @(negedge clk_100MHz);
      if (clk_out[idx] !== p) n = c;
    end
    chk("toggle_wait_expired", n >= 0, 1'b1);
  endtask
  initial begin
    int lat, n, sum;
    int t [6];
    logic dn, er, r1, lvl, seen;
    rst = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch = '0;
    cfg_digit = '0;
    run_en = 2'b00;
    repeat (3) @(negedge clk_100MHz);
    chk("reset_ready", cfg_ready, 1'b1);
    chk("reset_done", cfg_done, 1'b0);
    chk("reset_err", cfg_err, 1'b0);
    chk("reset_clk_out", clk_out, 2'b00);
    rst = 1'b1;
    run_en = 2'b01;
    @(negedge clk_100MHz);
    do_cfg(1'b0, 4'h0, 4'h0, 4'h1, 4'hd, lat, dn, er, r1);
    chk("1mhz_latency", lat, 11);
    chk("1mhz_done", dn, 1'b1);
    chk("1mhz_err", er, 1'b0);
    chk("busy_ready_low", r1, 1'b0);
    wait_toggle(0, n);
    chk("1mhz_first_half", n, 50);
    wait_toggle(0, n);
    chk("1mhz_half", n, 50);
    chk("ch1_idle_low", clk_out[1], 1'b0);
    run_en = 2'b11;
    do_cfg(1'b1, 4'h0, 4'h0, 4'h3, 4'hd, lat, dn, er, r1);
    chk("3mhz_latency", lat, 11);
    chk("3mhz_done", dn, 1'b1);
    sum = 0;
    for (int i = 0; i < 6; i++) begin
      wait_toggle(1, t[i]);
      sum += t[i];
    end
    chk("3mhz_int0", t[0], 17);
    chk("3mhz_int1", t[1], 17);
    chk("3mhz_int2", t[2], 16);
    chk("3mhz_100cyc", sum, 100);
    do_cfg(1'b0, 4'h0, 4'h6, 4'h0, 4'hd, lat, dn, er, r1);
    chk("60mhz_latency", lat, 11);
    chk("60mhz_err", er, 1'b1);
    chk("60mhz_no_done", dn, 1'b0);
    wait_toggle(0, n);
    wait_toggle(0, n);
    chk("60mhz_keeps_1mhz", n, 50);
    do_cfg(1'b0, 4'h0, 4'hA, 4'h0, 4'hd, lat, dn, er, r1);
    chk("bad_digit_latency", lat, 2);
    chk("bad_digit_err", er, 1'b1);
    chk("bad_digit_no_done", dn, 1'b0);
    @(negedge clk_100MHz);
    chk("after_err_ready", cfg_ready, 1'b1);
    chk("err_one_cycle", cfg_err, 1'b0);
    do_cfg(1'b0, 4'h0, 4'h0, 4'h1, 4'h5, lat, dn, er, r1);
    chk("bad_unit_latency", lat, 2);
    chk("bad_unit_err", er, 1'b1);
    if (clk_out[1] == 1'b0) wait_toggle(1, n);
    chk("ch1_high_before_disable", clk_out[1], 1'b1);
    run_en = 2'b01;
    @(negedge clk_100MHz);
    chk("ch1_disabled_low", clk_out[1], 1'b0);
    wait_toggle(0, n);
    lvl = clk_out[0];
    do_cfg(1'b0, 4'h0, 4'h0, 4'h2, 4'hd, lat, dn, er, r1);
    chk("2mhz_latency", lat, 11);
    chk("2mhz_no_glitch", clk_out[0], lvl);
    wait_toggle(0, n);
    chk("2mhz_continuous_toggle", n, 19);
    wait_toggle(0, n);
    chk("2mhz_half", n, 25);
    do_cfg(1'b0, 4'h5, 4'h0, 4'h0, 4'hb, lat, dn, er, r1);
    chk("500hz_latency", lat, 5);
    chk("500hz_done", dn, 1'b1);
    run_en = 2'b11;
    cfg_ch = 1'b1;
    cfg_digit = {4'hd, 4'h1, 4'h0, 4'h0};
    cfg_valid = 1'b1;
    @(posedge clk_100MHz);
    #1 cfg_valid = 1'b0;
    repeat (4) @(negedge clk_100MHz);
    rst = 1'b0;
    #1;
    chk("abort_clk_out", clk_out, 2'b00);
    chk("abort_ready", cfg_ready, 1'b1);
    chk("abort_done", cfg_done, 1'b0);
    chk("abort_err", cfg_err, 1'b0);
    @(negedge clk_100MHz);
    rst = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk_100MHz);
      seen = seen | cfg_done | cfg_err;
    end
    chk("abort_no_pulse", seen, 1'b0);
    repeat (120) @(negedge clk_100MHz);
    chk("abort_inc_cleared", clk_out, 2'b00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
